// File: rtl/clk_div_sched.sv
// ---------------------------------------------------------------------------
// clk_div_sched
//
// Run controller for the programmable odd/even 50%-duty clock divider core.
// Owns the divider's divisor and enable, accepts divisor/burst settings over
// a valid/ready handshake, and starts/stops the divider only on whole divided
// periods so the divider never emits a runt pulse. Counts completed divided
// periods and supports free-run (burst = 0) or a fixed burst of periods.
//
// Ports:
//   clk         system clock, shared with the divider core
//   rst         synchronous, active-low reset
//   cfg_valid   configuration offer
//   cfg_ready   configuration accept (registered)
//   cfg_n       requested divisor, legal range 2..2^NW-1
//   cfg_burst   periods per run, 0 = free-run
//   start       single-cycle run request (honoured in IDLE only)
//   stop        single-cycle stop request (honoured in RUN only)
//   div_wrap    one-clk pulse from the divider at the end of each period
//   div_en      divider enable
//   div_n       divisor presented to the divider
//   div_load    one-clk pulse: divider reloads counters/phase flops
//   busy        high in LOAD, RUN and DRAIN
//   done        one-clk pulse when a run ends
//   err         one-clk pulse when a configuration is rejected
//   period_cnt  divided periods completed in the current/last run
// ---------------------------------------------------------------------------
module clk_div_sched #(
    parameter int NW    = 4,
    parameter int CW    = 8,
    parameter int N_DEF = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [NW-1:0] cfg_n,
    input  logic [CW-1:0] cfg_burst,
    input  logic          start,
    input  logic          stop,
    input  logic          div_wrap,
    output logic          div_en,
    output logic [NW-1:0] div_n,
    output logic          div_load,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [CW-1:0] period_cnt
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    localparam logic [NW-1:0] N_MIN    = NW'(2);
    localparam logic [NW-1:0] N_RESET  = NW'(N_DEF);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

    // Registered state beyond the output ports
    logic [1:0]    state_r;
    logic [CW-1:0] burst_r;
    logic          pend_v_r;
    logic [NW-1:0] pend_n_r;
    logic [CW-1:0] pend_b_r;

    // Next-state values
    logic [1:0]    state_s;
    logic [CW-1:0] burst_s;
    logic          pend_v_s;
    logic [NW-1:0] pend_n_s;
    logic [CW-1:0] pend_b_s;
    logic          cfg_ready_s;
    logic          div_en_s;
    logic [NW-1:0] div_n_s;
    logic          div_load_s;
    logic          busy_s;
    logic          done_s;
    logic          err_s;
    logic [CW-1:0] period_cnt_s;

    // Handshake decode and period arithmetic
    logic          cfg_xfer_s;
    logic          cfg_bad_s;
    logic          cfg_ok_s;
    logic [CW-1:0] cnt_inc_s;
    logic          hit_burst_s;

    // Handshake qualification and burst-terminal detection
    always_comb begin
        cfg_xfer_s  = cfg_valid & cfg_ready;
        cfg_bad_s   = cfg_xfer_s & (cfg_n < N_MIN);
        cfg_ok_s    = cfg_xfer_s & ~cfg_bad_s;
        cnt_inc_s   = period_cnt + CNT_ONE;
        hit_burst_s = (burst_r != CNT_ZERO) && (cnt_inc_s == burst_r);
    end

    // Controller next-state and next-output logic
    always_comb begin
        state_s      = state_r;
        burst_s      = burst_r;
        pend_v_s     = pend_v_r;
        pend_n_s     = pend_n_r;
        pend_b_s     = pend_b_r;
        div_en_s     = div_en;
        div_n_s      = div_n;
        div_load_s   = 1'b0;
        busy_s       = busy;
        done_s       = 1'b0;
        err_s        = cfg_bad_s;
        period_cnt_s = period_cnt;

        case (state_r)
            ST_IDLE: begin
                // A config accepted alongside start is used by that run,
                // because the LOAD state reads the freshly written registers.
                if (cfg_ok_s) begin
                    div_n_s = cfg_n;
                    burst_s = cfg_burst;
                end else begin
                    div_n_s = div_n;
                    burst_s = burst_r;
                end
                if (start) begin
                    state_s      = ST_LOAD;
                    div_load_s   = 1'b1;
                    div_en_s     = 1'b0;
                    busy_s       = 1'b1;
                    period_cnt_s = CNT_ZERO;
                end else begin
                    state_s = ST_IDLE;
                    busy_s  = 1'b0;
                end
            end

            ST_LOAD: begin
                state_s  = ST_RUN;
                div_en_s = 1'b1;
                busy_s   = 1'b1;
            end

            ST_RUN: begin
                // cfg_ready is low while the slot is full, so a fresh
                // transfer can only land in an empty slot.
                if (cfg_ok_s) begin
                    pend_v_s = 1'b1;
                    pend_n_s = cfg_n;
                    pend_b_s = cfg_burst;
                end else begin
                    pend_v_s = pend_v_r;
                end
                if (div_wrap) begin
                    period_cnt_s = cnt_inc_s;
                    // Only a slot that was already full before this wrap is
                    // applied; one filling on this very cycle waits.
                    if (pend_v_r) begin
                        div_n_s  = pend_n_r;
                        burst_s  = pend_b_r;
                        pend_v_s = 1'b0;
                    end else begin
                        div_n_s = div_n;
                        burst_s = burst_r;
                    end
                    if (hit_burst_s || stop) begin
                        state_s  = ST_IDLE;
                        div_en_s = 1'b0;
                        busy_s   = 1'b0;
                        done_s   = 1'b1;
                    end else begin
                        state_s    = ST_RUN;
                        div_load_s = pend_v_r;
                    end
                end else if (stop) begin
                    state_s = ST_DRAIN;
                end else begin
                    state_s = ST_RUN;
                end
            end

            ST_DRAIN: begin
                // Keep the divider running to the end of its current period.
                if (div_wrap) begin
                    state_s      = ST_IDLE;
                    div_en_s     = 1'b0;
                    busy_s       = 1'b0;
                    done_s       = 1'b1;
                    period_cnt_s = cnt_inc_s;
                    // A config accepted just before stop would otherwise be
                    // stranded; commit it here without reloading the divider.
                    if (pend_v_r) begin
                        div_n_s  = pend_n_r;
                        burst_s  = pend_b_r;
                        pend_v_s = 1'b0;
                    end else begin
                        div_n_s = div_n;
                        burst_s = burst_r;
                    end
                end else begin
                    state_s = ST_DRAIN;
                end
            end

            default: begin
                state_s  = ST_IDLE;
                div_en_s = 1'b0;
                busy_s   = 1'b0;
                pend_v_s = 1'b0;
            end
        endcase

        // Ready for the next cycle: open in IDLE, and in RUN while the slot is free.
        cfg_ready_s = (state_s == ST_IDLE) || ((state_s == ST_RUN) && !pend_v_s);
    end

    // State and registered outputs, with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            burst_r    <= CNT_ZERO;
            pend_v_r   <= 1'b0;
            pend_n_r   <= N_RESET;
            pend_b_r   <= CNT_ZERO;
            cfg_ready  <= 1'b1;
            div_en     <= 1'b0;
            div_n      <= N_RESET;
            div_load   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            period_cnt <= CNT_ZERO;
        end else begin
            state_r    <= state_s;
            burst_r    <= burst_s;
            pend_v_r   <= pend_v_s;
            pend_n_r   <= pend_n_s;
            pend_b_r   <= pend_b_s;
            cfg_ready  <= cfg_ready_s;
            div_en     <= div_en_s;
            div_n      <= div_n_s;
            div_load   <= div_load_s;
            busy       <= busy_s;
            done       <= done_s;
            err        <= err_s;
            period_cnt <= period_cnt_s;
        end
    end

endmodule

// File: tb/tb_clk_div_sched.sv
// ---------------------------------------------------------------------------
// tb_clk_div_sched
//
// Self-checking bench for clk_div_sched. Each cycle the bench drives inputs,
// pushes the hand-derived expected output vector onto a scoreboard queue,
// then after the clock edge pops it and compares against the DUT outputs.
// Vector layout: {cfg_ready, div_en, div_n, div_load, busy, done, err, period_cnt}.
// ---------------------------------------------------------------------------
module tb_clk_div_sched;

    logic       clk;
    logic       rst;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [3:0] cfg_n;
    logic [7:0] cfg_burst;
    logic       start;
    logic       stop;
    logic       div_wrap;
    logic       div_en;
    logic [3:0] div_n;
    logic       div_load;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] period_cnt;

    int checks_r;
    int failures_r;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_t;

    sb_t sb_q[$];

    clk_div_sched #(
        .NW    (4),
        .CW    (8),
        .N_DEF (7)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_n      (cfg_n),
        .cfg_burst  (cfg_burst),
        .start      (start),
        .stop       (stop),
        .div_wrap   (div_wrap),
        .div_en     (div_en),
        .div_n      (div_n),
        .div_load   (div_load),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .period_cnt (period_cnt)
    );

    // 10-unit system clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Pack an expected output vector from per-field values
    function automatic logic [31:0] ov(input int cr, input int en, input int n,
                                       input int ld, input int bz, input int dn,
                                       input int er, input int pc);
        return {14'd0, cr[0], en[0], n[3:0], ld[0], bz[0], dn[0], er[0], pc[7:0]};
    endfunction

    // Compare one observed value against its expectation
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_r = checks_r + 1;
        if (obs !== exp) begin
            failures_r = failures_r + 1;
            $display("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Queue the expectation, advance one edge, then score the DUT outputs
    task automatic step(input string tag, input logic [31:0] exp);
        sb_t item;
        sb_t got;
        item.tag = tag;
        item.exp = exp;
        sb_q.push_back(item);
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        check_eq(got.tag, {14'd0, cfg_ready, div_en, div_n, div_load, busy, done, err, period_cnt},
                 got.exp);
        start     = 1'b0;
        stop      = 1'b0;
        div_wrap  = 1'b0;
        cfg_valid = 1'b0;
    endtask

    // Present a configuration for the next edge
    task automatic offer(input int n, input int b);
        cfg_valid = 1'b1;
        cfg_n     = n[3:0];
        cfg_burst = b[7:0];
    endtask

    initial begin
        checks_r   = 0;
        failures_r = 0;
        rst        = 1'b0;
        cfg_valid  = 1'b0;
        cfg_n      = 4'd0;
        cfg_burst  = 8'd0;
        start      = 1'b0;
        stop       = 1'b0;
        div_wrap   = 1'b0;

        // Reset held for three cycles
        for (int i = 0; i < 3; i++) step("reset", ov(1, 0, 7, 0, 0, 0, 0, 0));
        rst = 1'b1;

        // Burst of 3 periods at N=5
        offer(5, 3);                 step("burst_cfg",   ov(1, 0, 5, 0, 0, 0, 0, 0));
        start = 1'b1;                step("burst_load",  ov(0, 0, 5, 1, 1, 0, 0, 0));
                                     step("burst_run",   ov(1, 1, 5, 0, 1, 0, 0, 0));
                                     step("burst_gap",   ov(1, 1, 5, 0, 1, 0, 0, 0));
        div_wrap = 1'b1;             step("burst_w1",    ov(1, 1, 5, 0, 1, 0, 0, 1));
        div_wrap = 1'b1;             step("burst_w2",    ov(1, 1, 5, 0, 1, 0, 0, 2));
        div_wrap = 1'b1;             step("burst_w3",    ov(1, 0, 5, 0, 0, 1, 0, 3));
                                     step("burst_hold",  ov(1, 0, 5, 0, 0, 0, 0, 3));

        // Free-run at N=7, reconfigure to N=9 after two wraps
        offer(7, 0);                 step("fr_cfg",      ov(1, 0, 7, 0, 0, 0, 0, 3));
        start = 1'b1;                step("fr_load",     ov(0, 0, 7, 1, 1, 0, 0, 0));
                                     step("fr_run",      ov(1, 1, 7, 0, 1, 0, 0, 0));
        div_wrap = 1'b1;             step("fr_w1",       ov(1, 1, 7, 0, 1, 0, 0, 1));
        div_wrap = 1'b1;             step("fr_w2",       ov(1, 1, 7, 0, 1, 0, 0, 2));
        offer(9, 0);                 step("fr_pend",     ov(0, 1, 7, 0, 1, 0, 0, 2));
        start = 1'b1;                step("fr_start_ign",ov(0, 1, 7, 0, 1, 0, 0, 2));
        div_wrap = 1'b1;             step("fr_apply",    ov(1, 1, 9, 1, 1, 0, 0, 3));
                                     step("fr_after",    ov(1, 1, 9, 0, 1, 0, 0, 3));

        // Rejected configs in RUN leave everything but err untouched
        offer(1, 4);                 step("bad1_run",    ov(1, 1, 9, 0, 1, 0, 1, 3));
        offer(0, 4);                 step("bad0_run",    ov(1, 1, 9, 0, 1, 0, 1, 3));
        div_wrap = 1'b1;             step("bad_nopend",  ov(1, 1, 9, 0, 1, 0, 0, 4));

        // Stop between wraps drains to the next wrap
        stop = 1'b1;                 step("drain_enter", ov(0, 1, 9, 0, 1, 0, 0, 4));
                                     step("drain_hold",  ov(0, 1, 9, 0, 1, 0, 0, 4));
        div_wrap = 1'b1;             step("drain_done",  ov(1, 0, 9, 0, 0, 1, 0, 5));
                                     step("idle_hold",   ov(1, 0, 9, 0, 0, 0, 0, 5));
        stop = 1'b1; div_wrap = 1'b1; step("idle_ign",   ov(1, 0, 9, 0, 0, 0, 0, 5));

        // Rejected configs in IDLE
        offer(1, 2);                 step("bad1_idle",   ov(1, 0, 9, 0, 0, 0, 1, 5));
        offer(0, 2);                 step("bad0_idle",   ov(1, 0, 9, 0, 0, 0, 1, 5));

        // Stop coincident with a wrap ends the run without a drain cycle
        start = 1'b1;                step("col_load",    ov(0, 0, 9, 1, 1, 0, 0, 0));
                                     step("col_run",     ov(1, 1, 9, 0, 1, 0, 0, 0));
        div_wrap = 1'b1;             step("col_w1",      ov(1, 1, 9, 0, 1, 0, 0, 1));
        stop = 1'b1; div_wrap = 1'b1; step("col_done",   ov(1, 0, 9, 0, 0, 1, 0, 2));
                                     step("col_idle",    ov(1, 0, 9, 0, 0, 0, 0, 2));

        // start+stop+config in one IDLE cycle: start wins, new config used
        offer(4, 1); start = 1'b1; stop = 1'b1;
                                     step("ss_load",     ov(0, 0, 4, 1, 1, 0, 0, 0));
                                     step("ss_run",      ov(1, 1, 4, 0, 1, 0, 0, 0));
        div_wrap = 1'b1;             step("ss_done",     ov(1, 0, 4, 0, 0, 1, 0, 1));

        // Pending config applied on a terminal wrap: no div_load
        offer(6, 1);                 step("tp_cfg",      ov(1, 0, 6, 0, 0, 0, 0, 1));
        start = 1'b1;                step("tp_load",     ov(0, 0, 6, 1, 1, 0, 0, 0));
                                     step("tp_run",      ov(1, 1, 6, 0, 1, 0, 0, 0));
        offer(3, 5);                 step("tp_pend",     ov(0, 1, 6, 0, 1, 0, 0, 0));
        div_wrap = 1'b1;             step("tp_done",     ov(1, 0, 3, 0, 0, 1, 0, 1));

        // Reset mid-run discards the pending config
        offer(8, 0);                 step("rm_cfg",      ov(1, 0, 8, 0, 0, 0, 0, 1));
        start = 1'b1;                step("rm_load",     ov(0, 0, 8, 1, 1, 0, 0, 0));
                                     step("rm_run",      ov(1, 1, 8, 0, 1, 0, 0, 0));
        offer(11, 0);                step("rm_pend",     ov(0, 1, 8, 0, 1, 0, 0, 0));
        rst = 1'b0;                  step("rm_reset",    ov(1, 0, 7, 0, 0, 0, 0, 0));
        rst = 1'b1; start = 1'b1;    step("rm_load2",    ov(0, 0, 7, 1, 1, 0, 0, 0));
                                     step("rm_run2",     ov(1, 1, 7, 0, 1, 0, 0, 0));
        div_wrap = 1'b1;             step("rm_w1",       ov(1, 1, 7, 0, 1, 0, 0, 1));

        // Free-run period counter rolls over 255 -> 0 silently
        for (int i = 2; i <= 256; i++) begin
            div_wrap = 1'b1;
            step("rollover", ov(1, 1, 7, 0, 1, 0, 0, i % 256));
        end
        stop = 1'b1;                 step("ro_drain",    ov(0, 1, 7, 0, 1, 0, 0, 0));
        div_wrap = 1'b1;             step("ro_done",     ov(1, 0, 7, 0, 0, 1, 0, 1));

        $display("TB_RESULT checks=%0d failures=%0d", checks_r, failures_r);
        $finish;
    end

endmodule
